// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: drives the PLL RESET pin, qualifies the (asynchronous)
// PLL lock through a 2-flop synchronizer and releases the system reset only
// after lock has been continuously stable. Start-up is retried a bounded
// number of times before FAULT is raised.
//
// Build option PLL_SEQ_AUTO_RECOVER_EN:
//   defined   - lock loss while running re-runs the full PLL start-up sequence
//   undefined - lock loss while running goes straight to the fault state
module pll_reset_sequencer #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 256,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3
) (
  input  logic       CLK_IN,
  input  logic       RESET,
  input  logic       RESTART,
  input  logic       PLL_LOCKED,
  output logic       PLL_RESET,
  output logic       SYS_RESET,
  output logic       READY,
  output logic       FAULT,
  output logic [3:0] RETRY_CNT
);

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {PRST, WAIT, STABLE, RUN, FLT} state_t;

  state_t        state;
  logic [HW-1:0] hold_cnt;
  logic [SW-1:0] stab_cnt;
  logic [TW-1:0] tmo_cnt;
  logic          lock_m, lock_s;

  // Two-flop synchronizer for the asynchronous PLL lock indication
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      lock_m <= 1'b0;
      lock_s <= 1'b0;
    end else begin
      lock_m <= PLL_LOCKED;
      lock_s <= lock_m;
    end
  end

  // Sequencer FSM; every output is updated on the same edge as its state change
  always_ff @(posedge CLK_IN) begin
    if (RESET || RESTART) begin
      // RESET and RESTART have identical effect on the sequencer; RESET alone
      // also clears the synchronizer above.
      state     <= PRST;
      hold_cnt  <= '0;
      stab_cnt  <= '0;
      tmo_cnt   <= '0;
      RETRY_CNT <= '0;
      PLL_RESET <= 1'b1;
      SYS_RESET <= 1'b1;
      READY     <= 1'b0;
      FAULT     <= 1'b0;
    end else begin
      case (state)
        PRST: begin
          if (hold_cnt == HW'(RST_HOLD_CYCLES - 1)) begin
            state     <= WAIT;
            hold_cnt  <= '0;
            tmo_cnt   <= '0;
            PLL_RESET <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        WAIT: begin
          if (lock_s) begin
            state    <= STABLE;
            stab_cnt <= '0;
          end else if (tmo_cnt == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            tmo_cnt   <= '0;
            hold_cnt  <= '0;
            PLL_RESET <= 1'b1;
            if (RETRY_CNT != 4'(MAX_RETRIES))
              RETRY_CNT <= RETRY_CNT + 4'd1;
            if (RETRY_CNT + 4'd1 >= 4'(MAX_RETRIES)) begin
              state <= FLT;
              FAULT <= 1'b1;
            end else begin
              state <= PRST;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        STABLE: begin
          // stab_cnt counts lock_s cycles seen after entry; any drop restarts
          // qualification with a fresh timeout window.
          if (!lock_s) begin
            state    <= WAIT;
            stab_cnt <= '0;
            tmo_cnt  <= '0;
          end else if (stab_cnt == SW'(LOCK_STABLE_CYCLES)) begin
            state     <= RUN;
            SYS_RESET <= 1'b0;
            READY     <= 1'b1;
          end else begin
            stab_cnt <= stab_cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s) begin
            SYS_RESET <= 1'b1;
            READY     <= 1'b0;
            PLL_RESET <= 1'b1;
`ifdef PLL_SEQ_AUTO_RECOVER_EN
            state     <= PRST;
            hold_cnt  <= '0;
`else
            state     <= FLT;
            FAULT     <= 1'b1;
`endif
          end
        end
        FLT: begin
          state <= FLT;
        end
        default: begin
          state     <= PRST;
          hold_cnt  <= '0;
          PLL_RESET <= 1'b1;
          SYS_RESET <= 1'b1;
          READY     <= 1'b0;
          FAULT     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed testbench for pll_reset_sequencer (RST_HOLD=4, LOCK_STABLE=8,
// TIMEOUT=32, MAX_RETRIES=2). Inputs change and outputs are sampled 1ns
// after each rising edge.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst, restart, locked;
  logic       pll_reset, sys_reset, ready, fault;
  logic [3:0] retry_cnt;

  int errors = 0;
  int checks = 0;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4), .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(32), .MAX_RETRIES(2)
  ) dut (
    .CLK_IN(clk), .RESET(rst), .RESTART(restart), .PLL_LOCKED(locked),
    .PLL_RESET(pll_reset), .SYS_RESET(sys_reset), .READY(ready),
    .FAULT(fault), .RETRY_CNT(retry_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until PLL_RESET is low; n = edges taken, -1 on budget expiry
  task automatic wait_pll_low(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (pll_reset === 1'b0) begin n = i; break; end
    end
  endtask

  // Ticks until SYS_RESET is low; first tick is the edge sampling new inputs
  task automatic wait_sys_low(output int n);
    n = -1;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (sys_reset === 1'b0) begin n = i; break; end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1; restart = 1'b0; locked = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; restart = 1'b0; locked = 1'b1;
    tick(); tick();
    checks++;
    if ({pll_reset, sys_reset, ready, fault, retry_cnt} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL reset_values: got pll=%b sys=%b rdy=%b flt=%b rc=%0d, want 1 1 0 0 0",
               pll_reset, sys_reset, ready, fault, retry_cnt);
    end
    rst = 1'b0; locked = 1'b0;
  endtask

  task automatic test_nominal();
    int n;
    apply_reset();
    wait_pll_low(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL nom_pll_hold: got %0d cycles, want 4", n); end
    repeat (9) tick();
    locked = 1'b1;
    wait_sys_low(n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL nom_release: got edge %0d, want 12 (e0+11)", n); end
    checks++;
    if ({ready, fault, pll_reset, retry_cnt} !== 7'b100_0000) begin
      errors++;
      $display("FAIL nom_run_outputs: got rdy=%b flt=%b pll=%b rc=%0d, want 1 0 0 0",
               ready, fault, pll_reset, retry_cnt);
    end
  endtask

  task automatic test_glitch();
    int n;
    apply_reset();
    wait_pll_low(n);
    locked = 1'b1;
    repeat (5) tick();
    locked = 1'b0;
    tick();
    locked = 1'b1;
    wait_sys_low(n);
    checks++;
    if (n !== 12) begin errors++; $display("FAIL glitch_release: got edge %0d, want 12 after second rise", n); end
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL glitch_ready: got %b, want 1", ready); end
  endtask

  task automatic test_timeout();
    int n;
    apply_reset();
    wait_pll_low(n);
    repeat (31) tick();
    checks++;
    if (retry_cnt !== 4'd0 || pll_reset !== 1'b0) begin
      errors++; $display("FAIL to_before1: got rc=%0d pll=%b, want 0 0", retry_cnt, pll_reset);
    end
    tick();
    checks++;
    if (retry_cnt !== 4'd1 || pll_reset !== 1'b1 || fault !== 1'b0) begin
      errors++; $display("FAIL to_attempt1: got rc=%0d pll=%b flt=%b, want 1 1 0", retry_cnt, pll_reset, fault);
    end
    wait_pll_low(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL to_pll_hold2: got %0d cycles, want 4", n); end
    repeat (32) tick();
    checks++;
    if ({retry_cnt, fault, pll_reset, sys_reset, ready} !== 8'b0010_1110) begin
      errors++;
      $display("FAIL to_fault: got rc=%0d flt=%b pll=%b sys=%b rdy=%b, want 2 1 1 1 0",
               retry_cnt, fault, pll_reset, sys_reset, ready);
    end
    repeat (40) tick();
    checks++;
    if (fault !== 1'b1 || retry_cnt !== 4'd2) begin
      errors++; $display("FAIL to_fault_hold: got flt=%b rc=%0d, want 1 2", fault, retry_cnt);
    end
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if ({retry_cnt, fault, pll_reset, sys_reset} !== 7'b0000_011) begin
      errors++;
      $display("FAIL to_restart: got rc=%0d flt=%b pll=%b sys=%b, want 0 0 1 1",
               retry_cnt, fault, pll_reset, sys_reset);
    end
    wait_pll_low(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL to_restart_hold: got %0d cycles, want 4", n); end
  endtask

  task automatic test_lock_loss();
    int n;
    apply_reset();
    locked = 1'b1;
    wait_sys_low(n);
    checks++;
    if (ready !== 1'b1) begin errors++; $display("FAIL ll_bringup: got rdy=%b, want 1", ready); end
    locked = 1'b0;
    n = -1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (sys_reset === 1'b1) begin n = i; break; end
    end
    checks++;
    if (n < 1 || n > 3 || ready !== 1'b0) begin
      errors++; $display("FAIL ll_detect: got edge %0d rdy=%b, want <=3 and 0", n, ready);
    end
`ifdef PLL_SEQ_AUTO_RECOVER_EN
    checks++;
    if (fault !== 1'b0 || pll_reset !== 1'b1) begin
      errors++; $display("FAIL ll_recover_prst: got flt=%b pll=%b, want 0 1", fault, pll_reset);
    end
    wait_pll_low(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL ll_recover_hold: got %0d cycles, want 4", n); end
    locked = 1'b1;
    wait_sys_low(n);
    checks++;
    if (n !== 12 || ready !== 1'b1 || fault !== 1'b0 || retry_cnt !== 4'd0) begin
      errors++;
      $display("FAIL ll_recover_run: got edge %0d rdy=%b flt=%b rc=%0d, want 12 1 0 0",
               n, ready, fault, retry_cnt);
    end
`else
    checks++;
    if (fault !== 1'b1 || pll_reset !== 1'b1) begin
      errors++; $display("FAIL ll_fault: got flt=%b pll=%b, want 1 1", fault, pll_reset);
    end
    locked = 1'b1;
    repeat (30) tick();
    checks++;
    if (fault !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0) begin
      errors++; $display("FAIL ll_fault_hold: got flt=%b sys=%b rdy=%b, want 1 1 0", fault, sys_reset, ready);
    end
`endif
  endtask

  task automatic test_priority();
    int n;
    apply_reset();
    locked = 1'b1;
    wait_sys_low(n);
    rst = 1'b1; restart = 1'b1;
    tick();
    rst = 1'b0; restart = 1'b0;
    checks++;
    if ({pll_reset, sys_reset, ready, fault, retry_cnt} !== 8'b1100_0000) begin
      errors++;
      $display("FAIL prio_reset: got pll=%b sys=%b rdy=%b flt=%b rc=%0d, want 1 1 0 0 0",
               pll_reset, sys_reset, ready, fault, retry_cnt);
    end
    // Lock held low: let one attempt fail, then collide RESTART with the second timeout
    locked = 1'b0;
    wait_pll_low(n);
    repeat (32) tick();
    checks++;
    if (retry_cnt !== 4'd1) begin errors++; $display("FAIL prio_first_to: got rc=%0d, want 1", retry_cnt); end
    wait_pll_low(n);
    repeat (31) tick();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    checks++;
    if (retry_cnt !== 4'd0 || fault !== 1'b0 || pll_reset !== 1'b1) begin
      errors++;
      $display("FAIL prio_restart_vs_to: got rc=%0d flt=%b pll=%b, want 0 0 1", retry_cnt, fault, pll_reset);
    end
  endtask

  initial begin
    rst = 1'b1; restart = 1'b0; locked = 1'b0;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_lock_loss();
    test_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
